// File: rtl/bits_serializer_pkg.sv
// Shared definitions for the symbol-to-bit serializer.
//   psk_mode_e  : modulation codes shared with the mapper; each code is also
//                 the number of bits per symbol for that mode.
//   cw_of       : width of the runtime bits-per-symbol field for a given N_MAX.
//   clamp_nbits : maps a requested bits-per-symbol onto 1..N_MAX.
package bits_serializer_pkg;

    typedef enum logic [1:0] {
        MODE_BPSK = 2'd1,
        MODE_QPSK = 2'd2,
        MODE_8PSK = 2'd3
    } psk_mode_e;

    function automatic int unsigned cw_of(input int unsigned n_max);
        return $clog2(n_max + 1);
    endfunction

    // A request of 0 is treated as 1. Requests above the datapath
    // maximum saturate to that maximum.
    function automatic int unsigned clamp_nbits(input int unsigned nb,
                                                input int unsigned n_max);
        if (nb == 0)
            return 1;
        else if (nb > n_max)
            return n_max;
        else
            return nb;
    endfunction

endpackage

// File: rtl/bits_serializer_sym_fifo2.sv
// sym_fifo2: two-entry register FIFO with a parametrised payload width.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   i_push     : write i_data (ignored while full)
//   i_data     : payload to write
//   i_pop      : drop the head entry (ignored while empty)
//   o_data     : head entry, valid while !o_empty
//   o_full     : two entries held
//   o_empty    : no entries held
//   o_count    : occupancy 0..2
module sym_fifo2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wp;
    logic         r_rp;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rp];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= 1'b0;
            r_rp    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push)
                r_wp <= ~r_wp;
            if (w_pop)
                r_rp <= ~r_rp;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wp] <= i_data;
    end

endmodule

// File: rtl/bits_serializer.sv
// bits_serializer: accepts M-bit PSK symbol words over a valid/ready
// handshake, buffers up to two of them, and emits 1..N_MAX bits per symbol
// as a serial stream with first/last-of-symbol flags and back-pressure.
//   clk, rst_n : clock, asynchronous active-low reset
//   bypass     : per-symbol BPSK mode, emits only I[BYPASS_SELECTION]
//   nbits      : per-symbol bit count (0 -> 1, above N_MAX -> N_MAX)
//   I, I_vld   : symbol word and its valid; I_rdy is the registered ready
//   O, O_vld   : serial bit and its valid; O_rdy is the downstream ready
//   O_first    : current bit is the first of its symbol
//   O_last     : current bit is the last of its symbol
module bits_serializer
    import bits_serializer_pkg::*;
#(
    parameter int unsigned M                = 8,
    parameter int unsigned N_MAX            = 4,
    parameter int unsigned BYPASS_SELECTION = 1,
    parameter bit          MSB_FIRST        = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     bypass,
    input  logic [cw_of(N_MAX)-1:0]  nbits,
    input  logic [M-1:0]             I,
    input  logic                     I_vld,
    output logic                     I_rdy,
    output logic                     O,
    output logic                     O_vld,
    input  logic                     O_rdy,
    output logic                     O_first,
    output logic                     O_last
);

    localparam int unsigned CW = cw_of(N_MAX);
    localparam int unsigned IW = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned SW = (N_MAX > 1) ? $clog2(N_MAX) : 1;
    localparam int unsigned PW = M + CW + 1;

    // Input side: clamp the configuration and store it with the word.
    logic [CW-1:0] w_in_k;
    logic [PW-1:0] w_in_payload;
    logic          w_push;
    logic          r_in_rdy;

    assign w_in_k       = bypass ? CW'(1) : CW'(clamp_nbits(32'(nbits), N_MAX));
    assign w_in_payload = {bypass, w_in_k, I};
    assign w_push       = I_vld && r_in_rdy;

    logic [PW-1:0] w_head;
    logic          w_full;
    logic          w_empty;
    logic [1:0]    w_count;
    logic          w_load;

    sym_fifo2 #(
        .W (PW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_in_payload),
        .i_pop   (w_load),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    logic          w_head_byp;
    logic [CW-1:0] w_head_k;
    logic [M-1:0]  w_head_word;

    assign w_head_byp  = w_head[PW-1];
    assign w_head_k    = w_head[M +: CW];
    assign w_head_word = w_head[M-1:0];

    // Output shifter: bit 0 of r_sh is always the bit on O.
    logic [N_MAX-1:0] r_sh;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    r_k;
    logic             r_busy;
    logic             w_first;
    logic             w_last;
    logic             w_adv;
    logic             w_full_next;
    logic [N_MAX-1:0] w_load_sh;

    assign w_first = r_busy && (r_cnt == '0);
    assign w_last  = r_busy && (r_cnt == r_k - CW'(1));
    assign w_load  = !w_empty && (!r_busy || (w_last && O_rdy));
    assign w_adv   = r_busy && O_rdy && !w_last;

    // Ready is registered from the next occupancy only, so a pop in the
    // same cycle never opens the input while the FIFO is full.
    assign w_full_next = (w_full && !w_load) ||
                         ((w_count == 2'd1) && w_push && !w_load);

    // The word is reordered at load time so that emission is always a
    // plain right shift, regardless of bit order or bypass.
    always_comb begin
        w_load_sh = '0;
        if (w_head_byp) begin
            w_load_sh[0] = w_head_word[BYPASS_SELECTION];
        end else begin
            for (int unsigned j = 0; j < N_MAX; j++) begin
                if (j < 32'(w_head_k))
                    w_load_sh[SW'(j)] = w_head_word[IW'(MSB_FIRST ?
                                        (32'(w_head_k) - 32'd1 - j) : j)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_rdy <= 1'b0;
            r_busy   <= 1'b0;
            r_sh     <= '0;
            r_cnt    <= '0;
            r_k      <= '0;
        end else begin
            r_in_rdy <= !w_full_next;
            if (w_load) begin
                r_busy <= 1'b1;
                r_sh   <= w_load_sh;
                r_cnt  <= '0;
                r_k    <= w_head_k;
            end else if (w_adv) begin
                r_sh  <= r_sh >> 1;
                r_cnt <= r_cnt + CW'(1);
            end else if (r_busy && O_rdy) begin
                // Last bit taken and nothing pending.
                r_busy <= 1'b0;
            end
        end
    end

    assign I_rdy   = r_in_rdy;
    assign O       = r_busy && r_sh[0];
    assign O_vld   = r_busy;
    assign O_first = w_first;
    assign O_last  = w_last;

endmodule

// File: tb/tb_bits_serializer.sv
// Self-checking bench for bits_serializer: an LSB-first and an MSB-first
// instance share all stimulus; a scoreboard of expected bits is filled on
// every accepted symbol and checked whenever O_vld is high.
module tb_bits_serializer;
    import bits_serializer_pkg::*;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       bypass = 1'b0;
    logic [2:0] nbits  = 3'd0;
    logic [7:0] I      = 8'd0;
    logic       I_vld  = 1'b0;
    logic       O_rdy  = 1'b0;

    logic I_rdy_a, O_a, O_vld_a, O_first_a, O_last_a;
    logic I_rdy_b, O_b, O_vld_b, O_first_b, O_last_b;

    always #5 clk = ~clk;

    bits_serializer #(
        .M (8), .N_MAX (4), .BYPASS_SELECTION (1), .MSB_FIRST (1'b0)
    ) dut_lsb (
        .clk (clk), .rst_n (rst_n), .bypass (bypass), .nbits (nbits),
        .I (I), .I_vld (I_vld), .I_rdy (I_rdy_a),
        .O (O_a), .O_vld (O_vld_a), .O_rdy (O_rdy),
        .O_first (O_first_a), .O_last (O_last_a)
    );

    bits_serializer #(
        .M (8), .N_MAX (4), .BYPASS_SELECTION (1), .MSB_FIRST (1'b1)
    ) dut_msb (
        .clk (clk), .rst_n (rst_n), .bypass (bypass), .nbits (nbits),
        .I (I), .I_vld (I_vld), .I_rdy (I_rdy_b),
        .O (O_b), .O_vld (O_vld_b), .O_rdy (O_rdy),
        .O_first (O_first_b), .O_last (O_last_b)
    );

    typedef struct {
        logic lsb;
        logic msb;
        logic first;
        logic last;
    } exp_t;

    typedef struct {
        logic [7:0]  w;
        logic        b;
        logic [2:0]  n;
        int unsigned k;
        logic [3:0]  el;   // bit j = j-th bit out of the LSB-first instance
        logic [3:0]  em;   // bit j = j-th bit out of the MSB-first instance
    } vec_t;

    exp_t        sb[$];
    int unsigned bit_cyc[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned pops    = 0;
    int unsigned accepts = 0;
    logic [3:0]  cur_lsb = 4'd0;
    logic [3:0]  cur_msb = 4'd0;
    int unsigned cur_k   = 0;
    exp_t        mon_e;

    function automatic void chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void chk32(input string name, input int unsigned act,
                                  input int unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: direct indexing of the word, independent of any shifting.
    function automatic void model(input logic [7:0] w, input logic b, input logic [2:0] n,
                                  output logic [3:0] el, output logic [3:0] em,
                                  output int unsigned k);
        k  = b ? 1 : ((n == 3'd0) ? 1 : ((n > 3'd4) ? 4 : int'(n)));
        el = 4'd0;
        em = 4'd0;
        for (int unsigned j = 0; j < k; j++) begin
            el[2'(j)] = b ? w[1] : w[3'(j)];
            em[2'(j)] = b ? w[1] : w[3'(k - 1 - j)];
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Output checker then input-side scoreboard fill, both away from posedge.
    always @(negedge clk) begin
        if (O_vld_a || O_vld_b) begin
            if (sb.size() == 0) begin
                chk32("unexpected_O_vld", {30'd0, O_vld_b, O_vld_a}, 0);
            end else begin
                mon_e = sb[0];
                chk1("O_vld_lsb", O_vld_a, 1'b1);
                chk1("O_vld_msb", O_vld_b, 1'b1);
                chk1("O_lsb", O_a, mon_e.lsb);
                chk1("O_msb", O_b, mon_e.msb);
                chk1("O_first_lsb", O_first_a, mon_e.first);
                chk1("O_first_msb", O_first_b, mon_e.first);
                chk1("O_last_lsb", O_last_a, mon_e.last);
                chk1("O_last_msb", O_last_b, mon_e.last);
                if (O_rdy) begin
                    void'(sb.pop_front());
                    pops <= pops + 1;
                    bit_cyc.push_back(cyc);
                end
            end
        end
        if (I_vld && I_rdy_a) begin
            chk1("I_rdy_msb", I_rdy_b, 1'b1);
            accepts <= accepts + 1;
            for (int unsigned j = 0; j < cur_k; j++)
                sb.push_back('{cur_lsb[2'(j)], cur_msb[2'(j)], j == 0, j == cur_k - 1});
        end
    end

    task automatic send(input logic [7:0] w, input logic b, input logic [2:0] n,
                        input logic [3:0] el, input logic [3:0] em, input int unsigned k);
        int unsigned t;
        t       = 0;
        I       = w;
        bypass  = b;
        nbits   = n;
        cur_lsb = el;
        cur_msb = em;
        cur_k   = k;
        I_vld   = 1'b1;
        @(negedge clk);
        while (!I_rdy_a && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (!I_rdy_a)
            chk1("send_timeout", I_rdy_a, 1'b1);
        @(posedge clk);
        #1;
        I_vld = 1'b0;
    endtask

    task automatic send_m(input logic [7:0] w, input logic b, input logic [2:0] n);
        logic [3:0]  el, em;
        int unsigned k;
        model(w, b, n, el, em, k);
        send(w, b, n, el, em, k);
    endtask

    task automatic drain(input string name);
        int unsigned t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk32({name, "_drained"}, sb.size(), 0);
        chk1({name, "_O_vld_low_lsb"}, O_vld_a, 1'b0);
        chk1({name, "_O_vld_low_msb"}, O_vld_b, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    vec_t        tbl[11];
    int unsigned total;
    int unsigned acc0;
    int unsigned pop0;
    int unsigned t;
    logic [3:0]  el4, em4;
    int unsigned k4;

    initial begin
        tbl[0]  = '{8'b0000_0010, 1'b0, 3'(MODE_QPSK), 2, 4'b0010, 4'b0001};
        tbl[1]  = '{8'b0000_0001, 1'b0, 3'(MODE_QPSK), 2, 4'b0001, 4'b0010};
        tbl[2]  = '{8'h02,        1'b1, 3'(MODE_QPSK), 1, 4'b0001, 4'b0001};
        tbl[3]  = '{8'h00,        1'b1, 3'(MODE_QPSK), 1, 4'b0000, 4'b0000};
        tbl[4]  = '{8'h02,        1'b1, 3'(MODE_QPSK), 1, 4'b0001, 4'b0001};
        tbl[5]  = '{8'b0000_0101, 1'b0, 3'(MODE_8PSK), 3, 4'b0101, 4'b0101};
        tbl[6]  = '{8'h5D,        1'b0, 3'd7,          4, 4'b1101, 4'b1011};
        tbl[7]  = '{8'hFE,        1'b0, 3'd0,          1, 4'b0000, 4'b0000};
        tbl[8]  = '{8'h01,        1'b0, 3'(MODE_BPSK), 1, 4'b0001, 4'b0001};
        tbl[9]  = '{8'h0C,        1'b0, 3'd4,          4, 4'b1100, 4'b0011};
        tbl[10] = '{8'hFD,        1'b1, 3'd4,          1, 4'b0000, 4'b0000};

        // Reset state
        #12;
        chk32("reset_outs_lsb", {27'd0, I_rdy_a, O_a, O_vld_a, O_first_a, O_last_a}, 0);
        chk32("reset_outs_msb", {27'd0, I_rdy_b, O_b, O_vld_b, O_first_b, O_last_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk1("I_rdy_before_edge", I_rdy_a, 1'b0);
        @(posedge clk);
        #1;
        chk1("I_rdy_after_edge", I_rdy_a, 1'b1);

        // Latency: valid driven after edge t, written at t+1, loaded at t+2
        O_rdy = 1'b1;
        model(8'h03, 1'b0, 3'd2, el4, em4, k4);
        I = 8'h03; bypass = 1'b0; nbits = 3'd2;
        cur_lsb = el4; cur_msb = em4; cur_k = k4;
        I_vld = 1'b1;
        @(posedge clk);
        #1;
        I_vld = 1'b0;
        chk1("lat_after_write", O_vld_a, 1'b0);
        @(posedge clk);
        #1;
        chk1("lat_after_load", O_vld_a, 1'b1);
        chk1("lat_first", O_first_a, 1'b1);
        drain("latency");

        // Table: back-to-back symbols, the stream must have no gaps
        bit_cyc.delete();
        total = 0;
        for (int unsigned i = 0; i < 11; i++) begin
            send(tbl[i].w, tbl[i].b, tbl[i].n, tbl[i].el, tbl[i].em, tbl[i].k);
            total += tbl[i].k;
        end
        drain("table");
        chk32("table_bits", bit_cyc.size(), total);
        if (bit_cyc.size() > 0)
            chk32("table_span", bit_cyc[$] - bit_cyc[0], total - 1);

        // Back-pressure: three accepted with O_rdy low, fourth refused
        O_rdy = 1'b0;
        acc0  = accepts;
        pop0  = pops;
        send_m(8'h01, 1'b0, 3'd2);
        send_m(8'h02, 1'b0, 3'd2);
        send_m(8'h03, 1'b0, 3'd2);
        model(8'hFF, 1'b0, 3'd2, el4, em4, k4);
        I = 8'hFF; cur_lsb = el4; cur_msb = em4; cur_k = k4;
        I_vld = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk1("bp_I_rdy_low", I_rdy_a, 1'b0);
        chk32("bp_accepted", accepts - acc0, 3);
        chk32("bp_held_flags", {29'd0, O_a, O_first_a, O_last_a}, 32'b110);
        @(posedge clk);
        #1;
        I_vld = 1'b0;
        O_rdy = 1'b1;
        drain("backpressure");
        chk32("bp_bits", pops - pop0, 6);

        // Configuration change while the first bit of a symbol is out
        pop0 = pops;
        send_m(8'b0000_0010, 1'b0, 3'd2);
        t = 0;
        while (!O_vld_a && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk1("cfg_first_bit", O_first_a, 1'b1);
        nbits = 3'd1;
        send_m(8'h01, 1'b0, 3'd1);
        drain("cfg_change");
        chk32("cfg_bits", pops - pop0, 3);

        // Asynchronous reset in the middle of a symbol with one pending
        send_m(8'hA5, 1'b0, 3'd4);
        send_m(8'h3C, 1'b0, 3'd4);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk32("arst_outs_lsb", {27'd0, I_rdy_a, O_a, O_vld_a, O_first_a, O_last_a}, 0);
        chk32("arst_outs_msb", {27'd0, I_rdy_b, O_b, O_vld_b, O_first_b, O_last_b}, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk1("arst_I_rdy_before_edge", I_rdy_a, 1'b0);
        @(posedge clk);
        #1;
        chk1("arst_I_rdy_after_edge", I_rdy_a, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk1("arst_no_stale_lsb", O_vld_a, 1'b0);
        chk1("arst_no_stale_msb", O_vld_b, 1'b0);
        send_m(8'h06, 1'b0, 3'd2);
        drain("post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
